// File: rtl/uart_driver_cfg.sv
// ---------------------------------------------------------------------------
// uart_driver_cfg
//   Full-duplex UART PHY with a configurable frame (data bits, parity, stop
//   bits) and RX error detection. Bit timers and shift registers are built in.
//
//   Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//     defined   : each RX bit is the majority of three samples taken at
//                 mid-1, mid and mid+1; the bit decision (and rx_new_data)
//                 lands one cycle later than the single-sample build.
//     undefined : one sample at mid-bit.
//
//   Ports
//     sys_clk        system clock
//     rst            asynchronous reset, active low
//     tx_start       start a frame (only honoured while tx_ready=1)
//     tx_data        payload, captured in the tx_start cycle
//     tx_ready       transmitter idle
//     tx_out         registered serial output, idle high
//     rx_in          asynchronous serial input
//     rx_data        last received payload
//     rx_new_data    one-cycle pulse when a frame completes
//     rx_ready       receiver idle
//     rx_parity_err  parity mismatch on the last frame
//     rx_frame_err   a stop bit was sampled low on the last frame
// ---------------------------------------------------------------------------
module uart_driver_cfg #(
  parameter int BIT_DURATION  = 104,
  parameter int NUM_DATA_BITS = 8,
  parameter int PARITY_MODE   = 0,
  parameter int NUM_STOP_BITS = 1
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     tx_start,
  input  logic [NUM_DATA_BITS-1:0] tx_data,
  output logic                     tx_ready,
  output logic                     tx_out,
  input  logic                     rx_in,
  output logic [NUM_DATA_BITS-1:0] rx_data,
  output logic                     rx_new_data,
  output logic                     rx_ready,
  output logic                     rx_parity_err,
  output logic                     rx_frame_err
);

  localparam int HAS_PARITY = (PARITY_MODE != 0) ? 1 : 0;
  localparam int FRAME_BITS = 1 + NUM_DATA_BITS + HAS_PARITY + NUM_STOP_BITS;
  localparam int TW = $clog2(BIT_DURATION);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(BIT_DURATION - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(NUM_DATA_BITS - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(NUM_STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_MODE == 2);
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [TW-1:0] START_SAMPLE = TW'(BIT_DURATION / 2);
`else
  localparam logic [TW-1:0] START_SAMPLE = TW'(BIT_DURATION / 2 - 1);
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------- transmitter ----------------
  state_t                   tx_state, tx_state_nxt;
  logic [TW-1:0]            tx_timer, tx_timer_nxt;
  logic [CW-1:0]            tx_cnt, tx_cnt_nxt;
  logic [NUM_DATA_BITS-1:0] tx_shift, tx_shift_nxt;
  logic                     tx_par, tx_par_nxt;
  logic                     tx_out_nxt;

  assign tx_ready = (tx_state == IDLE);

  // TX state and datapath registers; reset forces the line idle high.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      tx_state <= IDLE;
      tx_timer <= '0;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
      tx_out   <= 1'b1;
    end else begin
      tx_state <= tx_state_nxt;
      tx_timer <= tx_timer_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_shift <= tx_shift_nxt;
      tx_par   <= tx_par_nxt;
      tx_out   <= tx_out_nxt;
    end
  end

  // TX next state: tx_out is loaded with the next bit value on the last
  // cycle of the current bit so every bit lasts exactly BIT_DURATION cycles.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_timer_nxt = tx_timer + 1'b1;
    tx_cnt_nxt   = tx_cnt;
    tx_shift_nxt = tx_shift;
    tx_par_nxt   = tx_par;
    tx_out_nxt   = tx_out;
    case (tx_state)
      IDLE: begin
        tx_timer_nxt = '0;
        if (tx_start) begin
          tx_state_nxt = START;
          tx_shift_nxt = tx_data;
          tx_par_nxt   = (^tx_data) ^ ODD;
          tx_cnt_nxt   = '0;
          tx_out_nxt   = 1'b0;
        end
      end
      START: begin
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          tx_state_nxt = DATA;
          tx_out_nxt   = tx_shift[0];
        end
      end
      DATA: begin
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          if (tx_cnt == DATA_LAST) begin
            tx_cnt_nxt = '0;
            if (HAS_PARITY != 0) begin
              tx_state_nxt = PARITY;
              tx_out_nxt   = tx_par;
            end else begin
              tx_state_nxt = STOP;
              tx_out_nxt   = 1'b1;
            end
          end else begin
            tx_cnt_nxt   = tx_cnt + 1'b1;
            tx_shift_nxt = tx_shift >> 1;
            tx_out_nxt   = tx_shift[1];
          end
        end
      end
      PARITY: begin
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          tx_state_nxt = STOP;
          tx_out_nxt   = 1'b1;
        end
      end
      STOP: begin
        if (tx_timer == BIT_LAST) begin
          tx_timer_nxt = '0;
          if (tx_cnt == STOP_LAST) begin
            tx_state_nxt = IDLE;
          end else begin
            tx_cnt_nxt = tx_cnt + 1'b1;
          end
        end
      end
      default: tx_state_nxt = IDLE;
    endcase
  end

  // ---------------- receiver ----------------
  logic rx_sync1, rx_sync2, rx_prev;
  logic rx_fall, rx_bit;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  // Reset to 1 so leaving reset never looks like a start edge.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= rx_in;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync2;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] rx_hist;

  // Two previous synchronised samples; the vote is taken one cycle after mid.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_hist <= 2'b11;
    end else begin
      rx_hist <= {rx_hist[0], rx_sync2};
    end
  end

  assign rx_bit = (rx_hist[1] & rx_hist[0]) | (rx_hist[1] & rx_sync2) |
                  (rx_hist[0] & rx_sync2);
`else
  assign rx_bit = rx_sync2;
`endif

  state_t                   rx_state, rx_state_nxt;
  logic [TW-1:0]            rx_timer, rx_timer_nxt;
  logic [CW-1:0]            rx_cnt, rx_cnt_nxt;
  logic [NUM_DATA_BITS-1:0] rx_shift, rx_shift_nxt;
  logic                     rx_par_acc, rx_par_acc_nxt;
  logic                     rx_ferr_acc, rx_ferr_acc_nxt;
  logic [NUM_DATA_BITS-1:0] rx_data_nxt;
  logic                     rx_new_nxt, rx_perr_nxt, rx_ferr_nxt;

  assign rx_ready = (rx_state == IDLE);

  // RX state, working registers and the visible result registers.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_state      <= IDLE;
      rx_timer      <= '0;
      rx_cnt        <= '0;
      rx_shift      <= '0;
      rx_par_acc    <= 1'b0;
      rx_ferr_acc   <= 1'b0;
      rx_data       <= '0;
      rx_new_data   <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_state_nxt;
      rx_timer      <= rx_timer_nxt;
      rx_cnt        <= rx_cnt_nxt;
      rx_shift      <= rx_shift_nxt;
      rx_par_acc    <= rx_par_acc_nxt;
      rx_ferr_acc   <= rx_ferr_acc_nxt;
      rx_data       <= rx_data_nxt;
      rx_new_data   <= rx_new_nxt;
      rx_parity_err <= rx_perr_nxt;
      rx_frame_err  <= rx_ferr_nxt;
    end
  end

  // RX next state: the start bit is checked half a bit in, then every later
  // bit exactly one bit period after the previous decision. The frame is
  // closed at the last stop-bit sample, half a bit before the line frees up.
  always_comb begin
    rx_state_nxt    = rx_state;
    rx_timer_nxt    = rx_timer + 1'b1;
    rx_cnt_nxt      = rx_cnt;
    rx_shift_nxt    = rx_shift;
    rx_par_acc_nxt  = rx_par_acc;
    rx_ferr_acc_nxt = rx_ferr_acc;
    rx_data_nxt     = rx_data;
    rx_new_nxt      = 1'b0;
    rx_perr_nxt     = rx_parity_err;
    rx_ferr_nxt     = rx_frame_err;
    case (rx_state)
      IDLE: begin
        rx_timer_nxt = '0;
        if (rx_fall) begin
          rx_state_nxt    = START;
          rx_cnt_nxt      = '0;
          rx_par_acc_nxt  = 1'b0;
          rx_ferr_acc_nxt = 1'b0;
        end
      end
      START: begin
        if (rx_timer == START_SAMPLE) begin
          rx_timer_nxt = '0;
          rx_state_nxt = rx_bit ? IDLE : DATA;
        end
      end
      DATA: begin
        if (rx_timer == BIT_LAST) begin
          rx_timer_nxt   = '0;
          rx_shift_nxt   = {rx_bit, rx_shift[NUM_DATA_BITS-1:1]};
          rx_par_acc_nxt = rx_par_acc ^ rx_bit;
          if (rx_cnt == DATA_LAST) begin
            rx_cnt_nxt   = '0;
            rx_state_nxt = (HAS_PARITY != 0) ? PARITY : STOP;
          end else begin
            rx_cnt_nxt = rx_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (rx_timer == BIT_LAST) begin
          rx_timer_nxt   = '0;
          rx_par_acc_nxt = rx_par_acc ^ rx_bit;
          rx_state_nxt   = STOP;
        end
      end
      STOP: begin
        if (rx_timer == BIT_LAST) begin
          rx_timer_nxt    = '0;
          rx_ferr_acc_nxt = rx_ferr_acc | ~rx_bit;
          if (rx_cnt == STOP_LAST) begin
            rx_state_nxt = IDLE;
            rx_new_nxt   = 1'b1;
            rx_data_nxt  = rx_shift;
            rx_perr_nxt  = (HAS_PARITY != 0) ? (rx_par_acc ^ ODD) : 1'b0;
            rx_ferr_nxt  = rx_ferr_acc | ~rx_bit;
          end else begin
            rx_cnt_nxt = rx_cnt + 1'b1;
          end
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_driver_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_driver_cfg
//   Self-checking bench for uart_driver_cfg with BIT_DURATION=16, 8 data bits,
//   even parity and one stop bit. Expected values come from a frame-level
//   reference model (bit list of a frame) and from a table of known frames.
// ---------------------------------------------------------------------------
module tb_uart_driver_cfg;

  localparam int BD  = 16;
  localparam int NDB = 8;
  localparam int F   = 11;

  logic           sys_clk = 1'b0;
  logic           rst = 1'b0;
  logic           tx_start = 1'b0;
  logic [NDB-1:0] tx_data = '0;
  logic           tx_ready;
  logic           tx_out;
  logic           rx_in = 1'b1;
  logic [NDB-1:0] rx_data;
  logic           rx_new_data;
  logic           rx_ready;
  logic           rx_parity_err;
  logic           rx_frame_err;

  uart_driver_cfg #(
    .BIT_DURATION (BD),
    .NUM_DATA_BITS(NDB),
    .PARITY_MODE  (1),
    .NUM_STOP_BITS(1)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_out       (tx_out),
    .rx_in        (rx_in),
    .rx_data      (rx_data),
    .rx_new_data  (rx_new_data),
    .rx_ready     (rx_ready),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err)
  );

  // 10 ns clock
  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  // Cycle counter, advanced on every rising edge.
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse monitor: records every rx_new_data pulse and the values it carries.
  int       pulse_cnt = 0;
  int       width_err = 0;
  int       last_pulse_cyc = 0;
  logic [7:0] cap_data = '0;
  logic     cap_perr = 1'b0;
  logic     cap_ferr = 1'b0;
  logic     prev_new = 1'b0;
  always @(negedge sys_clk) begin
    if (rx_new_data) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      cap_data = rx_data;
      cap_perr = rx_parity_err;
      cap_ferr = rx_frame_err;
      if (prev_new) width_err++;
    end
    prev_new = rx_new_data;
  end

  typedef struct {
    logic [7:0] data;
    bit         flip_par;
    bit         stop_low;
    int         glitch;
    logic [7:0] exp_data;
    bit         exp_perr;
    bit         exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs[7];

  int       base_pulse;
  int       start_cyc;
  logic     mid_ready;
  logic [7:0] last_data = '0;
  bit       last_perr = 1'b0;
  bit       last_ferr = 1'b0;

  // Frame as sent on the wire, index 0 first: start, data LSB first,
  // even parity (optionally inverted), stop.
  function automatic logic [F-1:0] buildFrame(input logic [7:0] d, input bit flip,
                                              input bit stoplow);
    logic [F-1:0] fb;
    fb[0]   = 1'b0;
    fb[8:1] = d;
    fb[9]   = (^d) ^ flip;
    fb[10]  = ~stoplow;
    return fb;
  endfunction

  // What a receiver must report for a clean wire frame: {ferr, perr, data}.
  function automatic logic [9:0] rxModel(input logic [F-1:0] fb);
    logic [7:0] d;
    logic       perr, ferr;
    d = fb[8:1];
    perr = ^fb[9:1];
    ferr = ~fb[10];
    return {ferr, perr, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic waitTxReady();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 1000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 1000) checkOutput("tx_ready timeout", {31'd0, tx_ready}, 32'd1);
  endtask

  // Send one TX frame and check every bit boundary and the ready timing.
  // A second tx_start mid-frame with different data must be ignored.
  task automatic sendTx(input logic [7:0] d);
    logic [F-1:0] fb;
    int ph;
    int bi;
    fb = buildFrame(d, 1'b0, 1'b0);
    waitTxReady();
    tx_data  = d;
    tx_start = 1'b1;
    for (int c = 1; c <= F * BD + 1; c++) begin
      @(negedge sys_clk);
      if (c == 1) tx_start = 1'b0;
      if (c == 3 * BD) begin
        tx_start = 1'b1;
        tx_data  = ~d;
      end
      if (c == 3 * BD + 1) tx_start = 1'b0;
      if (c <= F * BD) begin
        ph = (c - 1) % BD;
        bi = (c - 1) / BD;
        if (ph == 0 || ph == BD / 2 || ph == BD - 1)
          checkOutput($sformatf("tx_out d=%0h bit%0d ph%0d", d, bi, ph),
                      {31'd0, tx_out}, {31'd0, fb[bi]});
        if (c == 1 || c == F * BD)
          checkOutput($sformatf("tx_ready busy d=%0h c=%0d", d, c),
                      {31'd0, tx_ready}, 32'd0);
      end else begin
        checkOutput($sformatf("tx_ready after frame d=%0h", d), {31'd0, tx_ready}, 32'd1);
        checkOutput($sformatf("tx_out idle d=%0h", d), {31'd0, tx_out}, 32'd1);
      end
    end
  endtask

  // Drive one RX frame (optionally with a one-cycle inverted glitch), then
  // a bit period of idle line.
  task automatic applyStimulus(input rx_vec_t v);
    logic [F-1:0] fb;
    fb = buildFrame(v.data, v.flip_par, v.stop_low);
    base_pulse = pulse_cnt;
    start_cyc  = cyc;
    for (int c = 0; c < F * BD; c++) begin
      rx_in = fb[c / BD] ^ (c == v.glitch);
      if (c == 2 * BD) mid_ready = rx_ready;
      @(negedge sys_clk);
    end
    rx_in = 1'b1;
    repeat (BD) @(negedge sys_clk);
  endtask

  task automatic checkRxResult(input string name, input logic [7:0] ed,
                               input bit ep, input bit ef);
    int lat;
    lat = last_pulse_cyc - start_cyc;
    checkOutput({name, " pulses"}, pulse_cnt - base_pulse, 32'd1);
    checkOutput({name, " pulse latency in window"},
                {31'd0, (lat >= (F - 1) * BD + BD / 2 && lat <= (F - 1) * BD + BD / 2 + 4)},
                32'd1);
    checkOutput({name, " data at pulse"}, {24'd0, cap_data}, {24'd0, ed});
    checkOutput({name, " perr at pulse"}, {31'd0, cap_perr}, {31'd0, ep});
    checkOutput({name, " ferr at pulse"}, {31'd0, cap_ferr}, {31'd0, ef});
    checkOutput({name, " rx_data held"}, {24'd0, rx_data}, {24'd0, ed});
    checkOutput({name, " rx_ready mid-frame"}, {31'd0, mid_ready}, 32'd0);
    checkOutput({name, " rx_ready after"}, {31'd0, rx_ready}, 32'd1);
    last_data = ed;
    last_perr = ep;
    last_ferr = ef;
  endtask

  initial begin
    logic [F-1:0] fb;
    logic [9:0]   m;
    rx_vec_t      rv;
    logic [F-1:0] rb;

    // Known RX frames and their required results.
    vecs[0] = '{8'h3C, 1'b0, 1'b0, -1, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, -1, 8'h3C, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b0, -1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'hA5, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b1};
`ifdef UART_RX_MAJORITY_VOTE_EN
    vecs[4] = '{8'h00, 1'b0, 1'b0, 56, 8'h00, 1'b0, 1'b0};
`else
    vecs[4] = '{8'h00, 1'b0, 1'b0, 56, 8'h04, 1'b1, 1'b0};
`endif
    vecs[5] = '{8'hFF, 1'b0, 1'b0, -1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h80, 1'b1, 1'b0, -1, 8'h80, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge sys_clk);
    checkOutput("reset tx_out", {31'd0, tx_out}, 32'd1);
    checkOutput("reset tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("reset rx_ready", {31'd0, rx_ready}, 32'd1);
    checkOutput("reset rx_new_data", {31'd0, rx_new_data}, 32'd0);
    checkOutput("reset rx_data", {24'd0, rx_data}, 32'd0);
    checkOutput("reset perr", {31'd0, rx_parity_err}, 32'd0);
    checkOutput("reset ferr", {31'd0, rx_frame_err}, 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge sys_clk);

    // TX: 0xA5, then back-to-back random frames
    $display("[TB] TX frames");
    sendTx(8'hA5);
    for (int i = 0; i < 4; i++) sendTx(8'($urandom_range(0, 255)));

    // RX: table of known frames
    $display("[TB] RX table");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkRxResult($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                    vecs[i].exp_ferr);
    end

    // RX: short low glitch while idle is a false start
    $display("[TB] RX idle glitch");
    base_pulse = pulse_cnt;
    rx_in = 1'b0;
    repeat (4) @(negedge sys_clk);
    rx_in = 1'b1;
    checkOutput("glitch rx_ready drops", {31'd0, rx_ready}, 32'd0);
    repeat (2 * BD) @(negedge sys_clk);
    checkOutput("glitch no pulse", pulse_cnt - base_pulse, 32'd0);
    checkOutput("glitch rx_ready back", {31'd0, rx_ready}, 32'd1);
    checkOutput("glitch rx_data kept", {24'd0, rx_data}, {24'd0, last_data});
    checkOutput("glitch perr kept", {31'd0, rx_parity_err}, {31'd0, last_perr});
    checkOutput("glitch ferr kept", {31'd0, rx_frame_err}, {31'd0, last_ferr});

    // RX: random frames against the frame model
    $display("[TB] RX random");
    for (int i = 0; i < 8; i++) begin
      rv.data     = 8'($urandom_range(0, 255));
      rv.flip_par = ($urandom_range(0, 3) == 0);
      rv.stop_low = ($urandom_range(0, 3) == 0);
      rv.glitch   = -1;
      fb = buildFrame(rv.data, rv.flip_par, rv.stop_low);
      m  = rxModel(fb);
      rv.exp_data = m[7:0];
      rv.exp_perr = m[8];
      rv.exp_ferr = m[9];
      applyStimulus(rv);
      checkRxResult($sformatf("rand%0d", i), rv.exp_data, rv.exp_perr, rv.exp_ferr);
    end

    // Reset in the middle of concurrent TX and RX frames
    $display("[TB] Reset mid-frame");
    waitTxReady();
    base_pulse = pulse_cnt;
    rb = buildFrame(8'h33, 1'b0, 1'b0);
    tx_data  = 8'h5A;
    tx_start = 1'b1;
    rx_in    = rb[0];
    for (int c = 1; c <= 4 * BD + 8; c++) begin
      @(negedge sys_clk);
      if (c == 1) tx_start = 1'b0;
      rx_in = rb[c / BD];
    end
    rst = 1'b0;
    #1;
    checkOutput("midreset tx_out", {31'd0, tx_out}, 32'd1);
    checkOutput("midreset tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("midreset rx_ready", {31'd0, rx_ready}, 32'd1);
    checkOutput("midreset rx_new_data", {31'd0, rx_new_data}, 32'd0);
    rx_in = 1'b1;
    repeat (3) @(negedge sys_clk);
    checkOutput("midreset rx_data cleared", {24'd0, rx_data}, 32'd0);
    rst = 1'b1;
    repeat (F * BD) @(negedge sys_clk);
    checkOutput("midreset no pulse", pulse_cnt - base_pulse, 32'd0);
    checkOutput("midreset tx idle", {31'd0, tx_ready}, 32'd1);
    checkOutput("midreset tx_out idle", {31'd0, tx_out}, 32'd1);
    checkOutput("midreset rx idle", {31'd0, rx_ready}, 32'd1);

    checkOutput("rx_new_data single-cycle", width_err, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
